// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: per-requester request channel and the
// shared, one-hot-qualified response bus.
interface alu_arbiter_if #(
    parameter int width = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*width-1:0] req_a;
    logic [NREQ*width-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [width-1:0]      resp_y;
    logic [2:0]            resp_onz;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_onz, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_y, resp_onz, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among NREQ requesters:
// IDLE arbitrates, EXEC lets the ALU settle on registered operands, RESP holds the result.
module alu_arbiter #(
    parameter int width = 8,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [width-1:0] alu_y,
    input  logic [2:0]       alu_onz,
    output logic [CNTW-1:0]  op_count
);
    localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST    = PW'(NREQ - 1);
    localparam logic [2:0]    OP_RSVD = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [width-1:0] a_q, a_d;
    logic [width-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [width-1:0] y_q, y_d;
    logic [2:0]       onz_q, onz_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]  ready_c;
    logic [NREQ-1:0]  resp_c;
    logic             win_found;
    logic [PW-1:0]    win_idx;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op == OP_RSVD;
    endfunction

    // First valid requester at or after rr_ptr, wrapping; the just-served one lands last.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        y_d      = y_q;
        onz_d    = onz_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        ready_c  = '0;
        resp_c   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_c[win_idx] = 1'b1;
                    a_d     = bus.req_a[int'(win_idx)*width +: width];
                    b_d     = bus.req_b[int'(win_idx)*3*0 + int'(win_idx)*width +: width];
                    op_d    = bus.req_op[int'(win_idx)*3 +: 3];
                    grant_d = win_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Reserved opcodes never expose whatever the ALU drives for them.
                if (is_reserved(op_q)) begin
                    y_d   = '0;
                    onz_d = '0;
                    err_d = 1'b1;
                end else begin
                    y_d   = alu_y;
                    onz_d = alu_onz;
                    err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_c[grant_q] = 1'b1;
                if (bus.resp_ready[grant_q]) begin
                    cnt_d    = cnt_q + CNTW'(1);
                    rr_ptr_d = nxt_ptr(grant_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            y_q      <= '0;
            onz_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            y_q      <= y_d;
            onz_q    <= onz_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // req_ready is combinational from req_valid, so it must be masked while reset is held.
    assign bus.req_ready  = rst ? '0 : ready_c;
    assign bus.resp_valid = resp_c;
    assign bus.resp_y     = y_q;
    assign bus.resp_onz   = onz_q;
    assign bus.resp_err   = err_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_op         = op_q;
    assign op_count       = cnt_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));
    a_resp_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.resp_valid));
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !((|bus.req_ready) && (|bus.resp_valid)));
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model, requester agents and a response scoreboard,
// driven by a vector table plus hand-written multi-cycle sequences.
module tb_alu_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.width(W), .NREQ(N)) bus ();

    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic [2:0]    alu_op, alu_onz;
    logic [CW-1:0] op_count;

    alu_arbiter #(.width(W), .NREQ(N), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_onz(alu_onz), .op_count(op_count)
    );

    // Bench ALU: {O,N,Z,Y}; O is the carry/borrow out of add/sub.
    function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        logic [8:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {1'b0, b};
            default: r = {1'b0, a} + {1'b0, b};
        endcase
        return {r[8], r[7], (r[7:0] == 8'h00), r[7:0]};
    endfunction

    always_comb {alu_onz, alu_y} = alu_model(alu_a, alu_b, alu_op);

    // Expected response word {err, onz, y}.
    function automatic logic [11:0] exp_resp(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        if (op == 3'b111) return 12'h800;
        return {1'b0, alu_model(a, b, op)};
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct { int id; logic [11:0] res; } sb_t;
    typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [11:0] exp; } vec_t;

    sb_t          sb_q[$];
    int           grants[$];
    int           acc_cyc[$];
    logic [N-1:0] pend, rrdy;
    logic [7:0]   ag_a[N], ag_b[N];
    logic [2:0]   ag_op[N];
    logic [11:0]  ag_exp[N];
    bit           auto_mode;
    int           checks, errors, cyc, cnt_model, acc_req, acc_resp, n_acc, last_id;
    vec_t         vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic load(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [11:0] e);
        ag_a[i] = a; ag_b[i] = b; ag_op[i] = op; ag_exp[i] = e; pend[i] = 1'b1;
    endtask

    task automatic load_rand(input int i);
        logic [7:0] a, b;
        logic [2:0] op;
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 3'($urandom_range(0, 7));
        load(i, a, b, op, exp_resp(a, b, op));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = pend[i];
            bus.req_a[i*W +: W]    = ag_a[i];
            bus.req_b[i*W +: W]    = ag_b[i];
            bus.req_op[i*3 +: 3]   = ag_op[i];
            bus.resp_ready[i]      = rrdy[i];
        end
    endtask

    task automatic sample();
        int  g;
        sb_t e;
        chk("op_count", 32'(op_count), cnt_model);
        if (bus.req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
            g = idx_of(bus.req_ready);
            chk("ready_had_valid", 32'(pend[g]), 1);
            sb_q.push_back('{id: g, res: ag_exp[g]});
            grants.push_back(g);
            acc_req = g;
        end
        if (bus.resp_valid != '0) begin
            chk("resp_onehot", 32'($onehot(bus.resp_valid)), 1);
            g = idx_of(bus.resp_valid);
            if (rrdy[g]) begin
                if (sb_q.size() == 0) begin
                    timeout("resp_unexpected");
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_id", g, e.id);
                    chk("resp_y", 32'(bus.resp_y), 32'(e.res[7:0]));
                    chk("resp_onz", 32'(bus.resp_onz), 32'(e.res[10:8]));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.res[11]));
                end
                acc_resp = g;
                last_id  = g;
                n_acc++;
                acc_cyc.push_back(cyc);
            end
        end
    endtask

    // One clock: apply agent updates just after the edge, sample mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_req >= 0) begin
            if (auto_mode) load_rand(acc_req);
            else pend[acc_req] = 1'b0;
        end
        if (acc_resp >= 0) cnt_model = (cnt_model + 1) % (1 << CW);
        acc_req  = -1;
        acc_resp = -1;
        drive();
        #3;
        sample();
    endtask

    task automatic clear_model();
        pend = '0; rrdy = '0; auto_mode = 1'b0;
        sb_q.delete();
        cnt_model = 0; acc_req = -1; acc_resp = -1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
        chk({tag, "_resp_y"}, 32'(bus.resp_y), 0);
        chk({tag, "_resp_onz"}, 32'(bus.resp_onz), 0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 0);
        chk({tag, "_alu_a"}, 32'(alu_a), 0);
        chk({tag, "_alu_b"}, 32'(alu_b), 0);
        chk({tag, "_alu_op"}, 32'(alu_op), 0);
        chk({tag, "_op_count"}, 32'(op_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        vt[0] = '{2, 8'h05, 8'h03, 3'd0, {1'b0, 3'b000, 8'h08}};
        vt[1] = '{0, 8'hFF, 8'h01, 3'd0, {1'b0, 3'b101, 8'h00}};
        vt[2] = '{1, 8'h03, 8'h05, 3'd1, {1'b0, 3'b110, 8'hFE}};
        vt[3] = '{3, 8'hF0, 8'h3C, 3'd2, {1'b0, 3'b000, 8'h30}};
        vt[4] = '{0, 8'hF0, 8'h0F, 3'd3, {1'b0, 3'b010, 8'hFF}};
        vt[5] = '{2, 8'hAA, 8'hAA, 3'd4, {1'b0, 3'b001, 8'h00}};
        vt[6] = '{1, 8'h0F, 8'h00, 3'd5, {1'b0, 3'b010, 8'hF0}};
        vt[7] = '{3, 8'h12, 8'h80, 3'd6, {1'b0, 3'b010, 8'h80}};
        vt[8] = '{0, 8'hFF, 8'h00, 3'd7, {1'b1, 3'b000, 8'h00}};
        vt[9] = '{1, 8'h01, 8'h01, 3'd0, {1'b0, 3'b000, 8'h02}};

        checks = 0; errors = 0; cyc = 0; n_acc = 0; last_id = -1;
        for (int i = 0; i < N; i++) begin
            ag_a[i] = '0; ag_b[i] = '0; ag_op[i] = '0; ag_exp[i] = '0;
        end

        // Reset state, with a request already pending that must not be acknowledged.
        rst = 1'b1;
        clear_model();
        load(0, 8'h5A, 8'hA5, 3'd3, 12'h0);
        drive();
        #12;
        chk_all_zero("reset");
        do_reset();

        // Single request from requester 2, cycle-by-cycle.
        load(2, 8'h05, 8'h03, 3'd0, {1'b0, 3'b000, 8'h08});
        rrdy = 4'b0100;
        tick();
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk("exec_ready", 32'(bus.req_ready), 0);
        chk("exec_valid", 32'(bus.resp_valid), 0);
        chk("exec_alu_a", 32'(alu_a), 32'h05);
        chk("exec_alu_b", 32'(alu_b), 32'h03);
        chk("exec_alu_op", 32'(alu_op), 0);
        tick();
        chk("single_resp_valid", 32'(bus.resp_valid), 32'h4);
        chk("single_resp_y", 32'(bus.resp_y), 32'h08);
        tick();
        chk("single_count", 32'(op_count), 1);
        chk("single_done", 32'(bus.resp_valid), 0);

        // Table of single operations covering every opcode and the reserved-op rule.
        rrdy = '1;
        for (int v = 0; v < 10; v++) begin
            base = n_acc;
            load(vt[v].id, vt[v].a, vt[v].b, vt[v].op, vt[v].exp);
            for (int t = 0; t < 8 && n_acc == base; t++) tick();
            if (n_acc == base) timeout("vec_response");
            else chk("vec_id", last_id, vt[v].id);
        end

        // Response backpressure on requester 1 while requester 0 waits.
        rrdy = '0;
        load(1, 8'h21, 8'h13, 3'd0, {1'b0, 3'b000, 8'h34});
        tick();
        chk("bp_grant1", 32'(bus.req_ready), 32'h2);
        load(0, 8'h44, 8'h11, 3'd2, {1'b0, 3'b001, 8'h00});
        rrdy = 4'b1101;
        tick();
        chk("bp_exec_ready", 32'(bus.req_ready), 0);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'h2);
            chk("bp_hold_y", 32'(bus.resp_y), 32'h34);
            chk("bp_hold_onz", 32'(bus.resp_onz), 0);
            chk("bp_no_ready", 32'(bus.req_ready), 0);
        end
        rrdy[1] = 1'b1;
        tick();
        tick();
        chk("bp_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        tick();

        // Reset during EXEC: rr_ptr is 3 beforehand, must restart at 0 afterwards.
        load(2, 8'h70, 8'h05, 3'd4, {1'b0, 3'b000, 8'h75});
        rrdy = '1;
        repeat (3) tick();
        load(1, 8'h0A, 8'h0B, 3'd0, {1'b0, 3'b000, 8'h15});
        tick();
        chk("rst_pre_grant", 32'(bus.req_ready), 32'h2);
        tick();
        chk("rst_pre_alu_a", 32'(alu_a), 32'h0A);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_exec");
        clear_model();
        rrdy = '1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rst_no_resp", 32'(bus.resp_valid), 0);
        end
        load(1, 8'h11, 8'h22, 3'd0, {1'b0, 3'b000, 8'h33});
        load(3, 8'h80, 8'h80, 3'd0, {1'b0, 3'b101, 8'h00});
        tick();
        chk("rst_rr_restart", 32'(bus.req_ready), 32'h2);
        base = n_acc;
        for (int t = 0; t < 12 && n_acc - base < 2; t++) tick();
        if (n_acc - base != 2) timeout("rst_drain");

        // Fairness: all requesters continuously valid.
        do_reset();
        grants.delete();
        acc_cyc.delete();
        auto_mode = 1'b1;
        rrdy = '1;
        for (int i = 0; i < N; i++) load_rand(i);
        repeat (18) tick();
        auto_mode = 1'b0;
        pend = '0;
        tick();
        chk("rr_count", 32'(op_count), 6);
        chk("rr_ngrants", grants.size(), 6);
        for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr_order", grants[k], k % N);
        for (int k = 1; k < acc_cyc.size(); k++) chk("rr_spacing", acc_cyc[k] - acc_cyc[k-1], 3);

        // Counter wrap with a 4-bit counter: 17 operations leave it at 1.
        do_reset();
        auto_mode = 1'b1;
        rrdy = '1;
        load_rand(3);
        base = n_acc;
        for (int t = 0; t < 100 && n_acc - base < 17; t++) tick();
        if (n_acc - base != 17) timeout("wrap_ops");
        auto_mode = 1'b0;
        pend = '0;
        tick();
        chk("wrap_count", 32'(op_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
